// File: rtl/img_pkg.sv
// Shared widths, writer state encoding and output beat payload for the window frame writer.
package img_pkg;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned WIDTH_W  = 13;
  localparam int unsigned HEIGHT_W = 11;
  localparam int unsigned MIN_DIM  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TOP,
    ST_LEFT,
    ST_BODY,
    ST_RIGHT,
    ST_BOTTOM
  } writer_state_e;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             sof;
    logic             eol;
    logic             eof;
  } out_beat_t;

  function automatic out_beat_t mk_beat(input logic [PIX_W-1:0] data,
                                        input logic sof, input logic eol, input logic eof);
    out_beat_t b;
    b.data = data;
    b.sof  = sof;
    b.eol  = eol;
    b.eof  = eof;
    return b;
  endfunction

endpackage

// File: rtl/window_frame_writer_if.sv
// Frame control, interior pixel input and raster output signals of the window frame writer.
interface window_frame_writer_if;
  import img_pkg::*;

  logic                start;
  logic [WIDTH_W-1:0]  image_width;
  logic [HEIGHT_W-1:0] image_height;
  logic [PIX_W-1:0]    in_data;
  logic                in_valid;
  logic                in_ready;
  logic [PIX_W-1:0]    out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_sof;
  logic                out_eol;
  logic                out_eof;
  logic                busy;
  logic                frame_done;

  modport slave (
    input  start, image_width, image_height, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sof, out_eol, out_eof, busy, frame_done
  );

  modport master (
    output start, image_width, image_height, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sof, out_eol, out_eof, busy, frame_done
  );
endinterface

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with a registered head stage; DEPTH counts memory plus head entries.
module pixel_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     mem_cnt_q;
  logic [DATA_W-1:0] head_q;
  logic              head_vld_q;
  logic              load;

  // Refill the head register whenever it is free or being consumed.
  assign load    = (!head_vld_q || pop_i) && (mem_cnt_q != '0);
  assign full_o  = (mem_cnt_q + CW'(head_vld_q)) == CW'(DEPTH);
  assign empty_o = !head_vld_q;
  assign head_o  = head_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (load) begin
        head_q     <= mem_q[rd_ptr_q];
        head_vld_q <= 1'b1;
        rd_ptr_q   <= rd_ptr_q + AW'(1);
      end else if (pop_i) begin
        head_vld_q <= 1'b0;
      end
      mem_cnt_q <= mem_cnt_q + CW'(push_i) - CW'(load);
    end
  end
endmodule

// File: rtl/window_frame_writer.sv
// Re-emits the interior pixel stream as a full W x H raster with a 1-pixel border and frame markers.
// Define BORDER_EDGE_EN to replicate each interior row's edge pixels into its left/right border.
module window_frame_writer
  import img_pkg::*;
#(
  parameter logic [PIX_W-1:0] BORDER_VALUE = 8'd0,
  parameter int unsigned      FIFO_DEPTH   = 16
) (
  input logic                  clk,
  input logic                  reset,
  window_frame_writer_if.slave bus
);
  writer_state_e       state_q;
  logic [WIDTH_W-1:0]  w_q, col_q, in_col_q;
  logic [HEIGHT_W-1:0] h_q, row_q, in_row_q;
  logic                busy_q, done_q, in_done_q, out_valid_q;
  out_beat_t           out_q;
  logic [PIX_W-1:0]    head;
  logic                fifo_full, fifo_empty, in_ready_c, push, pop, adv, last_col, start_ok;
`ifdef BORDER_EDGE_EN
  logic [PIX_W-1:0]    edge_q;
`endif

  assign adv        = !out_valid_q || bus.out_ready;
  assign in_ready_c = busy_q && !fifo_full && !in_done_q;
  assign push       = bus.in_valid && in_ready_c;
  assign pop        = adv && (state_q == ST_BODY) && !fifo_empty;
  assign last_col   = col_q == (w_q - WIDTH_W'(1));
  assign start_ok   = bus.start && (state_q == ST_IDLE) && !done_q &&
                      (bus.image_width >= WIDTH_W'(MIN_DIM)) &&
                      (bus.image_height >= HEIGHT_W'(MIN_DIM));

  pixel_fifo #(.DATA_W(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .wr_data_i (bus.in_data),
    .pop_i     (pop),
    .head_o    (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Interior input counter: stops accepting once (W-2)*(H-2) pixels are in.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_col_q  <= '0;
      in_row_q  <= '0;
      in_done_q <= 1'b0;
    end else if (start_ok) begin
      in_col_q  <= '0;
      in_row_q  <= '0;
      in_done_q <= 1'b0;
    end else if (push) begin
      if (in_col_q == (w_q - WIDTH_W'(3))) begin
        in_col_q <= '0;
        if (in_row_q == (h_q - HEIGHT_W'(3))) in_done_q <= 1'b1;
        else                                  in_row_q  <= in_row_q + HEIGHT_W'(1);
      end else begin
        in_col_q <= in_col_q + WIDTH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
`ifdef BORDER_EDGE_EN
      edge_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (adv) begin
        out_valid_q <= 1'b0;
        out_q       <= mk_beat(out_q.data, 1'b0, 1'b0, 1'b0);
        case (state_q)
          ST_IDLE: if (start_ok) begin
            // Pixel (0,0) is loaded together with the start so it is valid the next cycle.
            w_q         <= bus.image_width;
            h_q         <= bus.image_height;
            busy_q      <= 1'b1;
            col_q       <= WIDTH_W'(1);
            row_q       <= '0;
            out_valid_q <= 1'b1;
            out_q       <= mk_beat(BORDER_VALUE, 1'b1, 1'b0, 1'b0);
            state_q     <= ST_TOP;
          end
          ST_TOP: begin
            out_valid_q <= 1'b1;
            out_q       <= mk_beat(BORDER_VALUE, 1'b0, last_col, 1'b0);
            if (last_col) begin
              col_q   <= '0;
              row_q   <= HEIGHT_W'(1);
              state_q <= ST_LEFT;
            end else begin
              col_q <= col_q + WIDTH_W'(1);
            end
          end
          ST_LEFT: begin
`ifdef BORDER_EDGE_EN
            if (!fifo_empty) begin
              out_valid_q <= 1'b1;
              out_q       <= mk_beat(head, 1'b0, 1'b0, 1'b0);
              col_q       <= WIDTH_W'(1);
              state_q     <= ST_BODY;
            end
`else
            out_valid_q <= 1'b1;
            out_q       <= mk_beat(BORDER_VALUE, 1'b0, 1'b0, 1'b0);
            col_q       <= WIDTH_W'(1);
            state_q     <= ST_BODY;
`endif
          end
          ST_BODY: if (!fifo_empty) begin
            out_valid_q <= 1'b1;
            out_q       <= mk_beat(head, 1'b0, 1'b0, 1'b0);
`ifdef BORDER_EDGE_EN
            edge_q      <= head;
`endif
            col_q       <= col_q + WIDTH_W'(1);
            if (col_q == (w_q - WIDTH_W'(2))) state_q <= ST_RIGHT;
          end
          ST_RIGHT: begin
            out_valid_q <= 1'b1;
`ifdef BORDER_EDGE_EN
            out_q       <= mk_beat(edge_q, 1'b0, 1'b1, 1'b0);
`else
            out_q       <= mk_beat(BORDER_VALUE, 1'b0, 1'b1, 1'b0);
`endif
            col_q       <= '0;
            if (row_q == (h_q - HEIGHT_W'(2))) state_q <= ST_BOTTOM;
            else                               state_q <= ST_LEFT;
            row_q       <= row_q + HEIGHT_W'(1);
          end
          ST_BOTTOM: begin
            // An eof beat still in the register means it was just accepted.
            if (out_q.eof) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              out_valid_q <= 1'b1;
              out_q       <= mk_beat(BORDER_VALUE, 1'b0, last_col, last_col);
              if (!last_col) col_q <= col_q + WIDTH_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_data   = out_q.data;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sof    = out_q.sof;
  assign bus.out_eol    = out_q.eol;
  assign bus.out_eof    = out_q.eof;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
endmodule
